id_operand_fetch: RTL and testbench



---
 rtl/id_operand_fetch.sv | 257 +++++++++++++++++++++++++
 tb/tb_id_operand_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: drives the register-file read ports from the
// incoming instruction, selects operands with EX/MEM forwarding, detects
// load-use hazards and registers the result into the ID/EX pipeline stage.
module id_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  output logic              re1,
  output logic [ADDR_W-1:0] raddr1,
  input  logic [DATA_W-1:0] rdata1,
  output logic              re2,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_wreg,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              out_illegal,
  output logic              stallreq
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Instruction fields
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [15:0]       imm16;

  assign op     = in_inst[31:26];
  assign funct  = in_inst[5:0];
  assign rs     = in_inst[21 +: ADDR_W];
  assign rt     = in_inst[16 +: ADDR_W];
  assign rd     = in_inst[11 +: ADDR_W];
  assign imm16  = in_inst[15:0];

  // Decoded class information
  logic              dec_re1;
  logic              dec_re2;
  logic              dec_wr;
  logic [ADDR_W-1:0] dec_dst;
  logic              dec_ill;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_wreg;

  // Opcode class decode: read-port usage, destination and legality.
  always_comb begin
    dec_re1 = 1'b0;
    dec_re2 = 1'b0;
    dec_wr  = 1'b0;
    dec_dst = '0;
    dec_ill = 1'b0;
    case (op) inside
      OP_RTYPE: begin
        dec_re1 = 1'b1;
        dec_re2 = 1'b1;
        dec_dst = rd;
        dec_wr  = (funct != FN_JR);
      end
      [6'b001000:6'b001110]: begin
        dec_re1 = 1'b1;
        dec_dst = rt;
        dec_wr  = 1'b1;
      end
      OP_LUI: begin
        dec_dst = rt;
        dec_wr  = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec_re1 = 1'b1;
        dec_dst = rt;
        dec_wr  = 1'b1;
      end
      OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE: begin
        dec_re1 = 1'b1;
        dec_re2 = 1'b1;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // Immediate extension: logical ops zero-extend, LUI shifts into the top half.
  always_comb begin
    dec_imm = {{(DATA_W-16){imm16[15]}}, imm16};
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
      dec_imm = {{(DATA_W-16){1'b0}}, imm16};
    end else if (op == OP_LUI) begin
      dec_imm = {imm16, {(DATA_W-16){1'b0}}};
    end
  end

  // A write to $0 is architecturally discarded, so never advertise it.
  assign dec_wreg = dec_wr && (dec_dst != '0);

  // Read-port drive; addresses are always the rs/rt fields.
  assign re1    = in_valid && dec_re1;
  assign re2    = in_valid && dec_re2;
  assign raddr1 = rs;
  assign raddr2 = rt;

  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;

  // Operand 1 selection; EX forwarding has priority over MEM.
  always_comb begin
    opnd1 = rdata1;
    if (!re1) begin
      opnd1 = '0;
    end else if (raddr1 == '0) begin
      opnd1 = '0;
    end else if (ex_we && ex_waddr == raddr1) begin
      opnd1 = ex_wdata;
    end else if (mem_we && mem_waddr == raddr1) begin
      opnd1 = mem_wdata;
    end
  end

  // Operand 2 selection; an unused port 2 carries the immediate instead.
  always_comb begin
    opnd2 = rdata2;
    if (!re2) begin
      opnd2 = dec_imm;
    end else if (raddr2 == '0) begin
      opnd2 = '0;
    end else if (ex_we && ex_waddr == raddr2) begin
      opnd2 = ex_wdata;
    end else if (mem_we && mem_waddr == raddr2) begin
      opnd2 = mem_wdata;
    end
  end

  // Load-use hazard: EX load data is not yet available for forwarding.
  logic hazard;
  assign hazard = in_valid && ex_is_load && ex_we && (ex_waddr != '0) &&
                  ((re1 && raddr1 == ex_waddr) || (re2 && raddr2 == ex_waddr));
  assign stallreq = hazard;

  // ID/EX register state
  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [DATA_W-1:0] inst_q,    inst_d;
  logic [DATA_W-1:0] reg1_q,    reg1_d;
  logic [DATA_W-1:0] reg2_q,    reg2_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              wreg_q,    wreg_d;
  logic [ADDR_W-1:0] waddr_q,   waddr_d;
  logic              illegal_q, illegal_d;

  assign in_ready = !hazard && (!valid_q || out_ready);

  // Next-state of the ID/EX register: flush, then backpressure hold, then
  // bubble on hazard, otherwise advance.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    imm_d     = imm_q;
    wreg_d    = wreg_q;
    waddr_d   = waddr_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (valid_q && !out_ready) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
    end else begin
      valid_d = in_valid;
      if (in_valid) begin
        pc_d      = in_pc;
        inst_d    = in_inst;
        reg1_d    = opnd1;
        reg2_d    = opnd2;
        imm_d     = dec_imm;
        wreg_d    = dec_wreg;
        waddr_d   = dec_dst;
        illegal_d = dec_ill;
      end
    end
  end

  // ID/EX register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      imm_q     <= '0;
      wreg_q    <= 1'b0;
      waddr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      imm_q     <= imm_d;
      wreg_q    <= wreg_d;
      waddr_q   <= waddr_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_inst    = inst_q;
  assign out_reg1    = reg1_q;
  assign out_reg2    = reg2_q;
  assign out_imm     = imm_q;
  assign out_wreg    = wreg_q;
  assign out_waddr   = waddr_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: directed scenarios followed by random traffic,
// all checked against a behavioural model of decode, forwarding and the
// ID/EX handshake.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_we, ex_is_load, mem_we;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;
  logic        flush, out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_reg1, out_reg2, out_imm;
  logic        out_wreg, out_illegal, stallreq;
  logic [4:0]  out_waddr;

  logic [31:0] regs [32];

  int n_vec = 0;
  int n_err = 0;

  // model of the ID/EX register
  logic        m_v, m_wr, m_ill;
  logic [31:0] m_pc, m_inst, m_r1, m_r2, m_imm;
  logic [4:0]  m_wa;

  always #5 clk = ~clk;

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  id_operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm),
    .out_wreg(out_wreg), .out_waddr(out_waddr), .out_illegal(out_illegal),
    .stallreq(stallreq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic        r1, r2, wr, ill;
    logic [4:0]  dst;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    int op;
    op = int'(i[31:26]);
    d.r1 = 0; d.r2 = 0; d.wr = 0; d.ill = 0; d.dst = 0;
    if (op == 0) begin
      d.r1 = 1; d.r2 = 1; d.dst = i[15:11]; d.wr = (i[5:0] != 6'd8);
    end else if (op >= 8 && op <= 15) begin
      d.r1 = (op != 15); d.dst = i[20:16]; d.wr = 1;
    end else if (op inside {32, 33, 35, 36, 37}) begin
      d.r1 = 1; d.dst = i[20:16]; d.wr = 1;
    end else if (op inside {40, 41, 43, 4, 5}) begin
      d.r1 = 1; d.r2 = 1;
    end else begin
      d.ill = 1;
    end
    if (op inside {12, 13, 14})   d.imm = 32'(i[15:0]);
    else if (op == 15)            d.imm = 32'(i[15:0]) * 32'h10000;
    else                          d.imm = 32'($signed(i[15:0]));
    if (d.dst == 0) d.wr = 0;
    return d;
  endfunction

  function automatic logic [31:0] ref_operand(input logic rd_en, input logic [4:0] a,
                                              input logic [31:0] unused_val);
    if (!rd_en)                       return unused_val;
    if (a == 0)                       return 32'h0;
    if (ex_we && ex_waddr == a)       return ex_wdata;
    if (mem_we && mem_waddr == a)     return mem_wdata;
    return regs[a];
  endfunction

  task automatic model_reset();
    m_v = 0; m_wr = 0; m_ill = 0; m_pc = 0; m_inst = 0;
    m_r1 = 0; m_r2 = 0; m_imm = 0; m_wa = 0;
  endtask

  task automatic check_regs(input string where);
    chk({where, ".out_valid"},   32'(out_valid),   32'(m_v));
    chk({where, ".out_pc"},      out_pc,           m_pc);
    chk({where, ".out_inst"},    out_inst,         m_inst);
    chk({where, ".out_reg1"},    out_reg1,         m_r1);
    chk({where, ".out_reg2"},    out_reg2,         m_r2);
    chk({where, ".out_imm"},     out_imm,          m_imm);
    chk({where, ".out_wreg"},    32'(out_wreg),    32'(m_wr));
    chk({where, ".out_illegal"}, 32'(out_illegal), 32'(m_ill));
    if (m_wr) chk({where, ".out_waddr"}, 32'(out_waddr), 32'(m_wa));
  endtask

  // Inputs are already driven (just after a negedge). Checks the combinational
  // outputs, advances the model, then checks the registered outputs after the edge.
  task automatic step(input string where);
    dec_t d;
    logic e1, e2, haz, rdy;
    logic [4:0] rs, rt;
    logic [31:0] o1, o2;
    d  = ref_decode(in_inst);
    rs = in_inst[25:21];
    rt = in_inst[20:16];
    e1 = in_valid && d.r1;
    e2 = in_valid && d.r2;
    haz = in_valid && ex_is_load && ex_we && ex_waddr != 0 &&
          ((e1 && rs == ex_waddr) || (e2 && rt == ex_waddr));
    rdy = !haz && (!m_v || out_ready);
    o1 = ref_operand(e1, rs, 32'h0);
    o2 = ref_operand(e2, rt, d.imm);
    #1;
    chk({where, ".re1"},      32'(re1),      32'(e1));
    chk({where, ".re2"},      32'(re2),      32'(e2));
    chk({where, ".raddr1"},   32'(raddr1),   32'(rs));
    chk({where, ".raddr2"},   32'(raddr2),   32'(rt));
    chk({where, ".stallreq"}, 32'(stallreq), 32'(haz));
    chk({where, ".in_ready"}, 32'(in_ready), 32'(rdy));
    if (flush) m_v = 0;
    else if (m_v && !out_ready) ;
    else if (haz) m_v = 0;
    else begin
      m_v = in_valid;
      if (in_valid) begin
        m_pc = in_pc; m_inst = in_inst; m_r1 = o1; m_r2 = o2;
        m_imm = d.imm; m_wr = d.wr; m_wa = d.dst; m_ill = d.ill;
      end
    end
    @(posedge clk);
    #1;
    check_regs(where);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_inst = 0; ex_we = 0; ex_waddr = 0; ex_wdata = 0;
    ex_is_load = 0; mem_we = 0; mem_waddr = 0; mem_wdata = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    @(negedge clk);
    in_valid = 1; in_pc = pc; in_inst = inst;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    idle_inputs();
    model_reset();
    rst = 1;
    #3;
    check_regs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // ORI $3,$1,0x8000
    regs[1] = 32'h1234_0000;
    issue(32'h100, {6'b001101, 5'd1, 5'd3, 16'h8000});
    step("ori");
    chk("ori.reg1", out_reg1, 32'h1234_0000);
    chk("ori.reg2", out_reg2, 32'h0000_8000);
    chk("ori.waddr", 32'(out_waddr), 32'd3);

    // ADDU $4,$2,$3 with EX and MEM both targeting $2
    issue(32'h104, {6'b0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h21});
    ex_we = 1; ex_waddr = 2; ex_wdata = 32'hAA;
    mem_we = 1; mem_waddr = 2; mem_wdata = 32'hBB;
    step("fwd_ex");
    chk("fwd_ex.reg1", out_reg1, 32'hAA);
    issue(32'h108, {6'b0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h21});
    ex_we = 0;
    step("fwd_mem");
    chk("fwd_mem.reg1", out_reg1, 32'hBB);
    mem_we = 0;

    // load-use on $5
    issue(32'h10c, {6'b0, 5'd5, 5'd0, 5'd6, 5'd0, 6'h21});
    ex_is_load = 1; ex_we = 1; ex_waddr = 5; ex_wdata = 32'h55;
    step("loaduse");
    chk("loaduse.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    ex_is_load = 0; ex_we = 0;
    step("loaduse_go");
    chk("loaduse_go.valid", 32'(out_valid), 32'd1);

    // backpressure: hold for several cycles, then release
    issue(32'h110, {6'b100011, 5'd1, 5'd9, 16'hFFFC});
    out_ready = 0;
    for (int k = 0; k < 4; k++) step("hold");
    chk("hold.pc", out_pc, 32'h10c);
    @(negedge clk);
    out_ready = 1;
    step("release");
    chk("release.pc", out_pc, 32'h110);

    // LUI, illegal opcode, write to $0
    issue(32'h114, {6'b001111, 5'd3, 5'd7, 16'h1234});
    step("lui");
    chk("lui.imm", out_imm, 32'h1234_0000);
    issue(32'h118, {6'b111111, 26'h123_4567});
    step("illegal");
    chk("illegal.flag", 32'(out_illegal), 32'd1);
    issue(32'h11c, {6'b001001, 5'd1, 5'd0, 16'h0001});
    step("wr_zero");
    chk("wr_zero.wreg", 32'(out_wreg), 32'd0);

    // flush together with an accept
    issue(32'h120, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21});
    flush = 1;
    step("flush");
    chk("flush.valid", 32'(out_valid), 32'd0);
    flush = 0;

    // asynchronous reset while stalled with a valid instruction
    issue(32'h124, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21});
    step("pre_rst");
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    step("stall_rst");
    #2;
    rst = 1;
    #1;
    model_reset();
    check_regs("async_rst");
    @(negedge clk);
    rst = 0;
    idle_inputs();

    // random traffic with a small register range to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      int pick;
      @(negedge clk);
      if (n % 97 == 0) for (int i = 0; i < 32; i++) regs[i] = $urandom;
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    op = 6'b000000;
        2:       op = 6'($urandom_range(8, 15));
        3:       op = 6'b100011;
        4:       op = 6'b100000;
        5:       op = 6'b101011;
        6:       op = 6'b000100;
        7:       op = 6'b001111;
        default: op = 6'($urandom);
      endcase
      in_valid   = ($urandom_range(0, 3) != 0);
      in_pc      = $urandom;
      in_inst    = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom),
                    ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom)};
      ex_we      = $urandom_range(0, 1) != 0;
      ex_waddr   = 5'($urandom_range(0, 7));
      ex_wdata   = $urandom;
      ex_is_load = ($urandom_range(0, 3) == 0);
      mem_we     = $urandom_range(0, 1) != 0;
      mem_waddr  = 5'($urandom_range(0, 7));
      mem_wdata  = $urandom;
      flush      = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
